// File: rtl/ps2_kbd_if.sv
// ps2_kbd_if: CPU peripheral bus strobe interface shared by the bus devices.
// The CPU side (master) drives read/write/in_bus; the device (slave) returns out_bus.
interface ps2_kbd_if;
   logic        read;
   logic        write;
   logic [15:0] in_bus;
   logic [15:0] out_bus;

   modport master (
      output read,
      output write,
      output in_bus,
      input  out_bus
   );

   modport slave (
      input  read,
      input  write,
      input  in_bus,
      output out_bus
   );
endinterface

// File: rtl/ps2_kbd_driver.sv
// ps2_kbd_driver: PS/2 keyboard receiver with a scan-code FIFO on the CPU bus.
// Frames (start, 8 data LSB first, odd parity, stop) are sampled on synced
// ps2_clk falling edges; complete bytes are pushed into a FIFO that the CPU
// pops with single-cycle read strobes. A write strobe clears the sticky flags
// (in_bus[0]) or flushes the FIFO (in_bus[1]).
// Optional build macro: PS2_PARITY_CHECK_EN -- when defined, frames with bad
// odd parity are dropped and flag parity_err; when undefined, the parity bit
// is not checked and parity_err reads as 0.
module ps2_kbd_driver #(
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic     clk,
   input  logic     rst,
   ps2_kbd_if.slave bus,
   input  logic     ps2_clk,
   input  logic     ps2_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } state_t;

`ifdef PS2_PARITY_CHECK_EN
   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction
`endif

   // ---------------- input synchronizers ----------------
   logic clk_s1_r, clk_s2_r, clk_prev_r;
   logic data_s1_r, data_s2_r;
   logic fall_s;

   // Two-flop synchronizers for both PS/2 lines plus one delay for edge detect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_s1_r   <= 1'b1;
         clk_s2_r   <= 1'b1;
         clk_prev_r <= 1'b1;
         data_s1_r  <= 1'b1;
         data_s2_r  <= 1'b1;
      end else begin
         clk_s1_r   <= ps2_clk;
         clk_s2_r   <= clk_s1_r;
         clk_prev_r <= clk_s2_r;
         data_s1_r  <= ps2_data;
         data_s2_r  <= data_s1_r;
      end
   end

   assign fall_s = clk_prev_r & ~clk_s2_r;

   // ---------------- receive FSM ----------------
   state_t        state_r;
   logic [2:0]    bit_cnt_r;
   logic [7:0]    shift_r;
   logic [TW-1:0] tmo_cnt_r;
   logic          push_req_r;
   logic [7:0]    push_byte_r;
`ifdef PS2_PARITY_CHECK_EN
   logic          parity_bit_r;
   logic          perr_req_r;
`endif

   // Frame receiver: shifts bits on each falling edge, abandons stalled frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         bit_cnt_r    <= 3'd0;
         shift_r      <= 8'h00;
         tmo_cnt_r    <= '0;
         push_req_r   <= 1'b0;
         push_byte_r  <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
         parity_bit_r <= 1'b0;
         perr_req_r   <= 1'b0;
`endif
      end else begin
         push_req_r <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         perr_req_r <= 1'b0;
`endif
         if (state_r == ST_IDLE) begin
            tmo_cnt_r <= '0;
            bit_cnt_r <= 3'd0;
            // A high data bit on an edge in IDLE is not a start bit.
            if (fall_s && !data_s2_r) begin
               state_r <= ST_DATA;
               shift_r <= 8'h00;
            end else begin
               state_r <= ST_IDLE;
            end
         end else if (!fall_s) begin
            // No edge this cycle: count toward abandoning the frame silently.
            if (tmo_cnt_r == TMO_LAST) begin
               state_r   <= ST_IDLE;
               tmo_cnt_r <= '0;
               bit_cnt_r <= 3'd0;
               shift_r   <= 8'h00;
            end else begin
               tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
         end else begin
            tmo_cnt_r <= '0;
            case (state_r)
               ST_DATA: begin
                  shift_r <= {data_s2_r, shift_r[7:1]};
                  if (bit_cnt_r == 3'd7) begin
                     bit_cnt_r <= 3'd0;
                     state_r   <= ST_PARITY;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 3'd1;
                  end
               end
               ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  parity_bit_r <= data_s2_r;
`endif
                  state_r <= ST_STOP;
               end
               ST_STOP: begin
`ifdef PS2_PARITY_CHECK_EN
                  if (!odd_parity_ok(shift_r, parity_bit_r)) begin
                     perr_req_r <= 1'b1;
                  end else if (data_s2_r) begin
                     push_req_r  <= 1'b1;
                     push_byte_r <= shift_r;
                  end else begin
                     push_req_r <= 1'b0;
                  end
`else
                  if (data_s2_r) begin
                     push_req_r  <= 1'b1;
                     push_byte_r <= shift_r;
                  end else begin
                     push_req_r <= 1'b0;
                  end
`endif
                  state_r <= ST_IDLE;
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // ---------------- FIFO and CPU bus ----------------
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_r, rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          overflow_r;
   logic          parity_err_s;
   logic [15:0]   out_bus_r;

   logic          empty_s, full_s, pop_s, clear_s, flush_s;
   logic          push_ok_s, ovf_set_s;
   logic [CW-1:0] count_next_s;
   logic          unused_in_bus;

   assign unused_in_bus = &{1'b0, bus.in_bus[15:2]};
   assign bus.out_bus   = out_bus_r;

   // Decode this cycle's push/pop/control actions against the current state.
   always_comb begin
      empty_s   = (count_r == {CW{1'b0}});
      full_s    = (count_r == CNT_FULL);
      pop_s     = bus.read & ~empty_s;
      clear_s   = bus.write & bus.in_bus[0];
      flush_s   = bus.write & bus.in_bus[1];
      push_ok_s = 1'b0;
      ovf_set_s = 1'b0;
      // A same-cycle pop frees a slot on a full FIFO, so the push still fits.
      if (push_req_r && !flush_s) begin
         if (full_s && !pop_s) begin
            ovf_set_s = 1'b1;
         end else begin
            push_ok_s = 1'b1;
         end
      end else begin
         push_ok_s = 1'b0;
      end
      count_next_s = count_r + CW'(push_ok_s) - CW'(pop_s);
   end

   // Storage array; pointers and count carry the reset state.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem[wr_ptr_r] <= push_byte_r;
      end
   end

   // Pointer/count/status update; reads see the state before any write action.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         overflow_r <= 1'b0;
         out_bus_r  <= 16'h0000;
      end else begin
         if (bus.read) begin
            out_bus_r <= {~empty_s, overflow_r, parity_err_s, 5'b00000,
                          empty_s ? 8'h00 : mem[rd_ptr_r]};
         end
         if (flush_s) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
         end else begin
            if (pop_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_ok_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
         end
         if (ovf_set_s) begin
            overflow_r <= 1'b1;
         end else if (clear_s) begin
            overflow_r <= 1'b0;
         end
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic parity_err_r;

   // Sticky parity error flag, cleared by a control write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_err_r <= 1'b0;
      end else if (perr_req_r) begin
         parity_err_r <= 1'b1;
      end else if (clear_s) begin
         parity_err_r <= 1'b0;
      end
   end

   assign parity_err_s = parity_err_r;
`else
   assign parity_err_s = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_kbd_driver.sv
// tb_ps2_kbd_driver: scoreboard bench for ps2_kbd_driver. A byte-queue model of
// the FIFO and flags produces the expected out_bus word for every read.
module tb_ps2_kbd_driver;
   localparam int DEPTH = 16;
   localparam int TMO   = 400;
   localparam int HALF  = 6;

   logic clk = 1'b0;
   logic rst;
   logic ps2_clk;
   logic ps2_data;

   ps2_kbd_if bus ();

   ps2_kbd_driver #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  model_q [$];
   logic        model_ovf  = 1'b0;
   logic        model_perr = 1'b0;
   logic [15:0] exp_q [$];

   task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_word();
      logic [7:0] head;
      head = (model_q.size() != 0) ? model_q[0] : 8'h00;
      return {(model_q.size() != 0), model_ovf, model_perr, 5'b00000, head};
   endfunction

   task automatic model_push(input logic [7:0] d);
      if (model_q.size() == DEPTH) model_ovf = 1'b1;
      else model_q.push_back(d);
   endtask

   task automatic model_pop();
      if (model_q.size() != 0) void'(model_q.pop_front());
   endtask

   // Pulse read for one cycle and compare the loaded word with the model.
   task automatic do_read(input string tag);
      exp_q.push_back(exp_word());
      model_pop();
      bus.read = 1'b1;
      @(posedge clk); #1;
      bus.read = 1'b0;
      chk_val(tag, bus.out_bus, exp_q.pop_front());
   endtask

   task automatic wr_ctrl(input logic [15:0] v);
      bus.write  = 1'b1;
      bus.in_bus = v;
      @(posedge clk); #1;
      bus.write  = 1'b0;
      bus.in_bus = 16'h0000;
      if (v[0]) begin
         model_ovf  = 1'b0;
         model_perr = 1'b0;
      end
      if (v[1]) model_q.delete();
   endtask

   // Drive the first n bits of a frame; optionally read during the push cycle.
   task automatic send_bits(input logic [7:0] d, input bit bad_par, input int n,
                            input bit rd_at_stop);
      logic [10:0] bits;
      bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(posedge clk);
         #1 ps2_clk = 1'b0;
         if (i == 10 && rd_at_stop) begin
            // Two sync stages, one FSM stage, then the push edge.
            repeat (3) @(posedge clk);
            #1;
            exp_q.push_back(exp_word());
            model_pop();
            bus.read = 1'b1;
            @(posedge clk); #1;
            bus.read = 1'b0;
            chk_val("read_at_push", bus.out_bus, exp_q.pop_front());
            repeat (HALF - 4) @(posedge clk);
         end else begin
            repeat (HALF) @(posedge clk);
         end
         #1 ps2_clk = 1'b1;
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d);
      send_bits(d, 1'b0, 11, 1'b0);
      model_push(d);
   endtask

   initial begin
      rst        = 1'b1;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      bus.read   = 1'b0;
      bus.write  = 1'b0;
      bus.in_bus = 16'h0000;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_val("reset_out", bus.out_bus, 16'h0000);
      do_read("reset_empty");

      // Single frame, then a read of the empty FIFO.
      send_frame(8'h1C);
      do_read("read_1c");
      do_read("read_empty");

      // Overflow: 17 frames into a 16-deep FIFO.
      for (int i = 0; i < 17; i++) send_frame(8'hA0 + 8'(i));
      for (int i = 0; i < 16; i++) do_read($sformatf("ovf_drain_%0d", i));
      wr_ctrl(16'h0001);
      do_read("ovf_cleared");

      // Bad parity frame.
      send_bits(8'h1C, 1'b1, 11, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
      model_perr = 1'b1;
`else
      model_push(8'h1C);
`endif
      do_read("bad_parity");
      wr_ctrl(16'h0001);
      do_read("perr_cleared");

      // Timeout: stall after 5 edges, then a clean frame must be received.
      send_bits(8'h33, 1'b0, 5, 1'b0);
      repeat (TMO + 10) @(posedge clk);
      #1;
      send_frame(8'hF0);
      do_read("after_timeout");

      // Full FIFO with a pop in the same cycle as the 17th push.
      for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i));
      send_bits(8'hB7, 1'b0, 11, 1'b1);
      model_push(8'hB7);
      for (int i = 0; i < 16; i++) do_read($sformatf("full_drain_%0d", i));
      do_read("full_empty");

      // Flush discards buffered bytes.
      send_frame(8'h11);
      send_frame(8'h22);
      wr_ctrl(16'h0002);
      do_read("after_flush");

      // Reset mid-frame with bytes buffered.
      send_frame(8'h01);
      send_frame(8'h02);
      send_frame(8'h03);
      send_frame(8'h04);
      do_read("pre_reset");
      send_bits(8'h77, 1'b0, 4, 1'b0);
      rst = 1'b1;
      #2;
      chk_val("rst_out", bus.out_bus, 16'h0000);
      @(posedge clk); #1;
      rst = 1'b0;
      model_q.delete();
      model_ovf  = 1'b0;
      model_perr = 1'b0;
      do_read("rst_empty");
      send_frame(8'h5A);
      do_read("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
